// File: rtl/ins_assembler.sv
// ins_assembler: decode-stage front end. Pairs instructions with their
// extension word when (ins & EXT_MASK) == EXT_MATCH, queues complete
// {ins, ext, has_ext} records in a DEPTH-entry FIFO and presents the head
// record to the decoder over a valid/ready handshake.
// Optional: define INS_ASSEMBLER_STATS_EN to add the ins_count/ext_count
// record counters.
module ins_assembler #(
  parameter int           W         = 16,
  parameter int           DEPTH     = 4,
  parameter logic [W-1:0] EXT_MASK  = 16'hF000,
  parameter logic [W-1:0] EXT_MATCH = 16'hF000,
  localparam int          LW        = $clog2(DEPTH + 1)
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  input  logic [W-1:0]  word,
  input  logic          word_valid,
  output logic          word_ready,
  input  logic          flush,
  output logic [W-1:0]  out_ins,
  output logic [W-1:0]  out_ext,
  output logic          out_has_ext,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] level,
`ifdef INS_ASSEMBLER_STATS_EN
  output logic [15:0]   ins_count,
  output logic [15:0]   ext_count,
`endif
  output logic          pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 2 * W + 1;

  typedef enum logic {IDLE, WAIT_EXT} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    hold_q, hold_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [RW-1:0]   mem [DEPTH];
  logic            accept, pop, push;
  logic [RW-1:0]   push_rec, head_rec;

  // Handshake qualifiers; flush blocks both sides for its cycle.
  always_comb begin
    word_ready = !cpu_rst && !flush && (level_q < LW'(DEPTH));
    accept     = word_valid && word_ready;
    out_valid  = (level_q != '0);
    pop        = out_valid && out_ready && !flush;
  end

  // Pairing FSM: decide next state, hold contents and the record to push.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    push     = 1'b0;
    push_rec = '0;
    if (flush) begin
      state_d = IDLE;
      hold_d  = '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if ((word & EXT_MASK) == EXT_MATCH) begin
            hold_d  = word;
            state_d = WAIT_EXT;
          end else begin
            push     = 1'b1;
            push_rec = {1'b0, {W{1'b0}}, word};
          end
        end
        WAIT_EXT: begin
          // The second word is taken verbatim as the extension.
          push     = 1'b1;
          push_rec = {1'b1, word, hold_q};
          hold_d   = '0;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and hold register.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // FIFO storage; contents are qualified by level so need no reset.
  always_ff @(posedge cpu_clk) begin
    if (push) mem[wr_ptr_q] <= push_rec;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Head record, forced to zero while the FIFO is empty.
  always_comb begin
    head_rec    = out_valid ? mem[rd_ptr_q] : '0;
    out_ins     = head_rec[W-1:0];
    out_ext     = head_rec[2*W-1:W];
    out_has_ext = head_rec[2*W];
    level       = level_q;
    pending     = (state_q == WAIT_EXT);
  end

`ifdef INS_ASSEMBLER_STATS_EN
  logic [15:0] ins_count_q, ext_count_q;

  // Record counters; survive flush, wrap at 16'hFFFF.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      ins_count_q <= '0;
      ext_count_q <= '0;
    end else if (push) begin
      ins_count_q <= ins_count_q + 16'd1;
      if (push_rec[2*W]) ext_count_q <= ext_count_q + 16'd1;
    end
  end

  assign ins_count = ins_count_q;
  assign ext_count = ext_count_q;
`endif

endmodule

// File: doc/ins_assembler.md
Name: ins_assembler

Overview:
- Front end of the decode stage. Takes a stream of raw fetched words over a valid/ready handshake.
- Pairs each instruction with its extension word when its encoding requires one.
- Buffers the complete {ins, ext, has_ext} records in a DEPTH-entry FIFO.
- Presents the head record to the decoder over valid/ready, replacing the single-cycle ins/ins_en/ext interface with a stall-tolerant, parametrised one.

Parameters:
- W, 16, word width of the instruction and extension words.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- EXT_MASK, 16'hF000, bits of the instruction examined for the extension rule (W bits wide).
- EXT_MATCH, 16'hF000, an extension word is required when (ins & EXT_MASK) == EXT_MATCH.

Ports:
- cpu_clk  in  1  clock.
- cpu_rst  in  1  asynchronous active-high reset.
- word  in  W  fetched word.
- word_valid  in  1  word is valid.
- word_ready  out  1  block accepts word this cycle.
- flush  in  1  synchronous discard of all buffered and partial state.
- out_ins  out  W  head instruction.
- out_ext  out  W  head extension word; 0 when out_has_ext=0.
- out_has_ext  out  1  head record carries an extension word.
- out_valid  out  1  head record valid.
- out_ready  in  1  decoder consumes head.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- pending  out  1  first half of a pair is held, waiting for its extension word.

Behaviour:
- Reset: asynchronous on cpu_rst=1 to IDLE; FIFO empty.
  - level=0, pending=0, out_valid=0.
  - out_ins=0, out_ext=0, out_has_ext=0.
  - Hold register = 0.
  - word_ready=0 while cpu_rst=1.
- Reset mid-pair discards the held word.
- Handshakes:
  - Accept = word_valid & word_ready.
  - Pop = out_valid & out_ready.
  - word_ready = !flush & (level < DEPTH), in both states.
  - There is no full-bypass: a pop in the same cycle does not raise word_ready.
- FSM state IDLE:
  - Accepted word matching the rule: latch it into the hold register, go to WAIT_EXT, no push.
  - Accepted word not matching: push {word, 0, 0}, stay in IDLE.
- FSM state WAIT_EXT:
  - Next accepted word is always treated as the extension and is never decoded against the rule.
  - Push {hold, word, 1}, return to IDLE.
- pending = (state == WAIT_EXT).
- FIFO:
  - Circular with log2(DEPTH)-bit pointers that wrap.
  - Push and pop in the same cycle leave level unchanged.
  - A record pushed at edge N is visible at the head after edge N if the FIFO was empty.
  - Accept-to-out_valid latency is 1 cycle; no combinational path from word to out_*.
- Outputs:
  - out_valid = (level != 0).
  - out_* show the head record, forced to 0 when empty.
  - out_* stay stable while out_valid & !out_ready.
- Flush:
  - At the next edge: FIFO emptied, state to IDLE, hold cleared.
  - Takes priority over a simultaneous accept or pop; neither takes effect.
  - word_ready=0 during the flush cycle.
- Arithmetic: level never exceeds DEPTH and never underflows; a pop when empty is impossible because out_valid=0.

Optional Feature:
- Macro: INS_ASSEMBLER_STATS_EN.
- Defined:
  - Adds ports ins_count out 16 and ext_count out 16.
  - ins_count increments once per pushed record.
  - ext_count increments once per pushed record with has_ext=1.
  - Both wrap at 16'hFFFF to 0.
  - Both are cleared by cpu_rst and are not cleared by flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan (defaults):
1. Reset -> hold cpu_rst=1 -> all outputs 0. Release reset -> word_ready=1, level=0.
2. Single word -> word=16'h1234 accepted -> next cycle out_valid=1, out_ins=16'h1234, out_has_ext=0, out_ext=0, level=1. Then out_ready=1 for 1 cycle -> level=0, out_valid=0.
3. Pair -> accept 16'hF00A -> pending=1, out_valid=0. Accept 16'hBEEF -> pending=0; next cycle out_ins=16'hF00A, out_ext=16'hBEEF, out_has_ext=1. Accepting 16'hF123 while pending yields out_ext=16'hF123, not a new pair.
4. Full -> out_ready=0, push 16'h0001..16'h0004 -> level=4, word_ready=0 even with out_ready=1 that cycle. After the pop -> level=3, word_ready=1, and 16'h0002 at the head.
5. Flush -> level=2, pending=1, pulse flush together with word_valid=1 and out_ready=1 -> level=0, pending=0, out_valid=0, nothing consumed. Then 16'h0007 -> single record.
6. Async reset mid-pair -> assert cpu_rst between 16'hF00A and its extension -> pending=0 immediately. The next 16'h0005 -> single record. With INS_ASSEMBLER_STATS_EN, after scenarios 2 and 3 in sequence -> ins_count=2, ext_count=1.
